reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with busy scoreboard for the multicycle RV32I core.
//  Two write ports: A for ALU/writeback, B for load return. NRD combinational read ports.
//  A per-register busy bit tracks outstanding producers so the control FSM can stall on RAW hazards.

---
 rtl/reg_file_sb.sv | 108 ++++++++++
 tb/tb_reg_file_sb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register busy scoreboard (x0 hardwired to zero).
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_rd,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [AW:0]           pending_cnt,
    output logic                  wr_collision,
    output logic                  issue_conflict
);

    localparam int unsigned NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            a_hit;
    logic            b_hit;
    logic            issue_hit;
    logic            coll_nxt;
    logic            conf_nxt;

    always_comb begin
        a_hit     = wa_en && (wa_addr != '0);
        b_hit     = wb_en && (wb_addr != '0);
        issue_hit = issue_en && (issue_rd != '0);
        coll_nxt  = a_hit && b_hit && (wa_addr == wb_addr);
        conf_nxt  = issue_hit && busy[issue_rd]
                    && !((a_hit && (wa_addr == issue_rd)) || (b_hit && (wb_addr == issue_rd)));

        // Set is applied after the clears so an issue beats a same-cycle write.
        busy_nxt = busy;
        if (a_hit)
            busy_nxt[wa_addr] = 1'b0;
        if (b_hit)
            busy_nxt[wb_addr] = 1'b0;
        if (issue_hit)
            busy_nxt[issue_rd] = 1'b1;

        cnt_nxt = '0;
        for (int unsigned r = 0; r < NREG; r++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy           <= '0;
            pending_cnt    <= '0;
            wr_collision   <= 1'b0;
            issue_conflict <= 1'b0;
        end else begin
            if (a_hit)
                regs[wa_addr] <= wa_data;
            // Port B is written last so it wins an address collision.
            if (b_hit)
                regs[wb_addr] <= wb_data;
            busy           <= busy_nxt;
            pending_cnt    <= cnt_nxt;
            wr_collision   <= coll_nxt;
            issue_conflict <= conf_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdv;
        logic            rbv;
        ra      = '0;
        rdv     = '0;
        rbv     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            rdv = (ra == '0) ? '0 : regs[ra];
            rbv = (ra == '0) ? 1'b0 : busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (b_hit && (wb_addr == ra)) begin
                rdv = wb_data;
                rbv = issue_hit && (issue_rd == ra);
            end else if (a_hit && (wa_addr == ra)) begin
                rdv = wa_data;
                rbv = issue_hit && (issue_rd == ra);
            end
`endif
            rd_data[i*XLEN +: XLEN] = rdv;
            rd_busy[i]              = rbv;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, reset corner cases, and randomized
// traffic checked against an array-based reference model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wa_en, wb_en, issue_en;
    logic [4:0]  wa_addr, wb_addr, issue_rd;
    logic [31:0] wa_data, wb_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [5:0]  pending_cnt;
    logic        wr_collision, issue_conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .AW(5), .NRD(2)) dut (
        .clk(clk), .rst(rst),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .pending_cnt(pending_cnt), .wr_collision(wr_collision),
        .issue_conflict(issue_conflict)
    );

    typedef struct {
        bit          wae; logic [4:0] waa; logic [31:0] wad;
        bit          wbe; logic [4:0] wba; logic [31:0] wbd;
        bit          iss; logic [4:0] ird;
        logic [4:0]  r0;  logic [4:0] r1;
        logic [31:0] d0;  bit b0; logic [31:0] d1; bit b1;
        int          cnt; bit coll; bit conf;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] X6_SAME_CYCLE = 32'hAA;
`else
    localparam logic [31:0] X6_SAME_CYCLE = 32'h0;
`endif

    vec_t        tbl [13];
    logic [31:0] mmem [32];
    bit          mbusy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        issue_en = 0; issue_rd = 0;
    endtask

    task automatic apply_row(input int n, input vec_t v);
        wa_en = v.wae; wa_addr = v.waa; wa_data = v.wad;
        wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
        issue_en = v.iss; issue_rd = v.ird;
        rd_addr = {v.r1, v.r0};
        @(negedge clk);
        chk($sformatf("row%0d rd0_data", n), rd_data[31:0], v.d0);
        chk($sformatf("row%0d rd0_busy", n), 32'(rd_busy[0]), 32'(v.b0));
        chk($sformatf("row%0d rd1_data", n), rd_data[63:32], v.d1);
        chk($sformatf("row%0d rd1_busy", n), 32'(rd_busy[1]), 32'(v.b1));
        @(posedge clk); #1;
        chk($sformatf("row%0d pending_cnt", n), 32'(pending_cnt), 32'(v.cnt));
        chk($sformatf("row%0d wr_collision", n), 32'(wr_collision), 32'(v.coll));
        chk($sformatf("row%0d issue_conflict", n), 32'(issue_conflict), 32'(v.conf));
    endtask

    function automatic logic [32:0] model_read(input logic [4:0] a);
        logic [31:0] d;
        bit          b;
        d = (a == 0) ? 32'h0 : mmem[a];
        b = (a == 0) ? 1'b0 : mbusy[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_addr != 0 && wb_addr == a) begin
            d = wb_data; b = issue_en && issue_rd == a;
        end else if (wa_en && wa_addr != 0 && wa_addr == a) begin
            d = wa_data; b = issue_en && issue_rd == a;
        end
`endif
        return {b, d};
    endfunction

    initial begin
        logic [32:0] e0, e1;
        bit          ecoll, econf;
        int          ecnt;

        idle();
        rd_addr = '0;
        rst = 1'b1;
        #12;

        // Everything reads zero and idle while reset is held.
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("rst rd0_data a%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("rst rd1_data a%0d", a), rd_data[63:32], 32'h0);
            chk($sformatf("rst busy a%0d", a), 32'(rd_busy), 32'h0);
        end
        chk("rst pending_cnt", 32'(pending_cnt), 32'h0);
        chk("rst wr_collision", 32'(wr_collision), 32'h0);
        chk("rst issue_conflict", 32'(issue_conflict), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        //            wae waa wad            wbe wba wbd    iss ird  r0 r1 d0            b0 d1            b1 cnt coll conf
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0,  5, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0};
        tbl[1]  = '{1, 0, 32'h1,        0, 0, 32'h0,  0, 0,  5, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 7,  0, 5, 32'h0,        0, 32'hDEADBEEF, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 32'h0,        1, 7, 32'h55, 0, 0,  7, 0, 32'h0,        1, 32'h0,        0, 0, 0, 0};
        tbl[4]  = '{1, 3, 32'h11,       1, 3, 32'h22, 0, 0,  7, 0, 32'h55,       0, 32'h0,        0, 0, 1, 0};
        tbl[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  3, 7, 32'h22,       0, 32'h55,       0, 0, 0, 0};
        tbl[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 9,  3, 9, 32'h22,       0, 32'h0,        0, 1, 0, 0};
        tbl[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 9,  9, 0, 32'h0,        1, 32'h0,        0, 1, 0, 1};
        tbl[8]  = '{1, 4, 32'h8,        0, 0, 32'h0,  1, 4,  9, 4, 32'h0,        1, 32'h0,        0, 2, 0, 0};
        tbl[9]  = '{1, 6, 32'hAA,       0, 0, 32'h0,  0, 0,  4, 6, 32'h8,        1, X6_SAME_CYCLE, 0, 2, 0, 0};
        tbl[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  6, 9, 32'hAA,       0, 32'h0,        1, 2, 0, 0};
        tbl[11] = '{1, 4, 32'h10,       0, 0, 32'h0,  1, 4,  4, 0, 32'h8,        1, 32'h0,        0, 2, 0, 0};
        tbl[12] = '{0, 0, 32'h0,        1, 9, 32'h1,  1, 5,  4, 9, 32'h10,       1, 32'h0,        1, 2, 0, 0};
        for (int n = 0; n < 13; n++)
            apply_row(n, tbl[n]);

        // Asynchronous reset mid-cycle with a write and an issue pending.
        wa_en = 1; wa_addr = 6; wa_data = 32'h77;
        issue_en = 1; issue_rd = 8;
        rd_addr = {5'd5, 5'd6};
        #2 rst = 1'b1;
        #1;
        chk("async rst x6 data", rd_data[31:0], 32'h0);
        chk("async rst busy", 32'(rd_busy), 32'h0);
        chk("async rst pending_cnt", 32'(pending_cnt), 32'h0);
        @(posedge clk); #1;
        chk("rst held write lost", rd_data[31:0], 32'h0);
        chk("rst held issue lost", 32'(pending_cnt), 32'h0);
        @(negedge clk) rst = 1'b0;
        rd_addr = {5'd8, 5'd6};
        @(posedge clk); #1;
        chk("post rst write", rd_data[31:0], 32'h77);
        chk("post rst issue busy", 32'(rd_busy[1]), 32'h1);
        chk("post rst pending_cnt", 32'(pending_cnt), 32'h1);
        idle();

        // Randomized traffic against the reference model, from a clean reset.
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            mmem[a] = 0; mbusy[a] = 0;
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int t = 0; t < 400; t++) begin
            wa_en    = ($urandom_range(0, 2) != 0);
            wa_addr  = 5'($urandom_range(0, 7));
            wa_data  = $urandom;
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            issue_en = ($urandom_range(0, 1) != 0);
            issue_rd = 5'($urandom_range(0, 7));
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            @(negedge clk);
            e0 = model_read(rd_addr[4:0]);
            e1 = model_read(rd_addr[9:5]);
            chk($sformatf("rnd%0d rd0_data", t), rd_data[31:0], e0[31:0]);
            chk($sformatf("rnd%0d rd1_data", t), rd_data[63:32], e1[31:0]);
            chk($sformatf("rnd%0d rd_busy", t), 32'(rd_busy), 32'({e1[32], e0[32]}));
            @(posedge clk);
            ecoll = wa_en && wb_en && wa_addr != 0 && wa_addr == wb_addr;
            econf = issue_en && issue_rd != 0 && mbusy[issue_rd]
                    && !(wa_en && wa_addr == issue_rd) && !(wb_en && wb_addr == issue_rd);
            if (wa_en && wa_addr != 0) begin mmem[wa_addr] = wa_data; mbusy[wa_addr] = 0; end
            if (wb_en && wb_addr != 0) begin mmem[wb_addr] = wb_data; mbusy[wb_addr] = 0; end
            if (issue_en && issue_rd != 0) mbusy[issue_rd] = 1;
            ecnt = 0;
            for (int a = 0; a < 32; a++) ecnt += int'(mbusy[a]);
            #1;
            chk($sformatf("rnd%0d pending_cnt", t), 32'(pending_cnt), 32'(ecnt));
            chk($sformatf("rnd%0d wr_collision", t), 32'(wr_collision), 32'(ecoll));
            chk($sformatf("rnd%0d issue_conflict", t), 32'(issue_conflict), 32'(econf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
